eio_controller: RTL and testbench

Sequencer between the RisKy1 core's External I/O port and up to `NUM_DEV` external I/O devices. It latches one CPU EIO request, decodes the target device from the address, runs a request/acknowledge handshake with that device, and returns data or a fault to the core. A bus watchdog turns hung accesses into faults. It sits in `top_tb1`-style tops between `RK1.EIO_bus` and devices such as `external_register`.

---
 rtl/eio_controller.sv | 193 +++++++++++++++++++
 tb/tb_eio_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eio_controller.sv
// eio_controller: latches one CPU EIO access, decodes the device window and runs a
// req/ack handshake with it. Optional bus watchdog enabled by defining EIO_TIMEOUT_EN.
module eio_controller #(
    parameter int          NUM_DEV  = 4,
    parameter logic [31:0] EIO_BASE = 32'h0040_0000,
    parameter int          WIN_BITS = 8
`ifdef EIO_TIMEOUT_EN
    ,
    parameter int          TO_CYCLES = 255
`endif
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    cpu_req,
    input  logic                    cpu_rd_wr,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wr_data,
    output logic                    cpu_ack,
    output logic                    cpu_ack_fault,
    output logic [31:0]             cpu_ack_data,
    output logic [NUM_DEV-1:0]      dev_req,
    output logic                    dev_rd_wr,
    output logic [WIN_BITS-1:0]     dev_addr,
    output logic [31:0]             dev_wr_data,
    input  logic [NUM_DEV-1:0]      dev_ack,
    input  logic [32*NUM_DEV-1:0]   dev_rd_data,
    output logic                    busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic                fault_q, fault_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [NUM_DEV-1:0]  dev_req_q, dev_req_d;
    logic                dev_rd_wr_q, dev_rd_wr_d;
    logic [WIN_BITS-1:0] dev_addr_q, dev_addr_d;
    logic [31:0]         dev_wr_data_q, dev_wr_data_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                cpu_ack_fault_q, cpu_ack_fault_d;
    logic [31:0]         cpu_ack_data_q, cpu_ack_data_d;
    logic                busy_q, busy_d;
`ifdef EIO_TIMEOUT_EN
    logic [15:0]         wdog_q, wdog_d;
`endif

    logic [31:0]         addr_diff;
    logic [31:0]         addr_quot;
    logic                decode_bad;
    logic [NUM_DEV-1:0]  ack_hit;
    logic                ack_sel;
    logic [31:0]         rd_pick [NUM_DEV];
    logic [31:0]         rd_sel;

    // The full quotient is range-checked so far-away addresses cannot alias a device.
    assign addr_diff  = cpu_addr - EIO_BASE;
    assign addr_quot  = addr_diff >> WIN_BITS;
    assign decode_bad = (cpu_addr < EIO_BASE) || (addr_quot >= 32'(NUM_DEV));

    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev
            assign ack_hit[gi] = dev_ack[gi] && (idx_q == 3'(gi));
            assign rd_pick[gi] = (idx_q == 3'(gi)) ? dev_rd_data[32*gi +: 32] : 32'd0;
        end
    endgenerate

    assign ack_sel = |ack_hit;

    always_comb begin
        rd_sel = 32'd0;
        for (int i = 0; i < NUM_DEV; i++) begin
            rd_sel = rd_sel | rd_pick[i];
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        fault_d         = fault_q;
        rdata_d         = rdata_q;
        dev_req_d       = dev_req_q;
        dev_rd_wr_d     = dev_rd_wr_q;
        dev_addr_d      = dev_addr_q;
        dev_wr_data_d   = dev_wr_data_q;
        cpu_ack_d       = 1'b0;
        cpu_ack_fault_d = 1'b0;
        cpu_ack_data_d  = 32'd0;
`ifdef EIO_TIMEOUT_EN
        wdog_d          = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    dev_rd_wr_d   = cpu_rd_wr;
                    dev_addr_d    = cpu_addr[WIN_BITS-1:0];
                    dev_wr_data_d = cpu_wr_data;
                    idx_d         = addr_quot[2:0];
                    if (decode_bad) begin
                        fault_d = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                dev_req_d = NUM_DEV'(1) << idx_q;
`ifdef EIO_TIMEOUT_EN
                wdog_d    = 16'd0;
`endif
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A device ack on the expiry cycle still counts as success.
                if (ack_sel) begin
                    rdata_d   = rd_sel;
                    fault_d   = 1'b0;
                    dev_req_d = '0;
                    state_d   = S_RESP;
                end
`ifdef EIO_TIMEOUT_EN
                else if (wdog_q == 16'(TO_CYCLES - 1)) begin
                    rdata_d   = 32'd0;
                    fault_d   = 1'b1;
                    dev_req_d = '0;
                    state_d   = S_RESP;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
`endif
            end
            S_RESP: begin
                cpu_ack_d       = 1'b1;
                cpu_ack_fault_d = fault_q;
                cpu_ack_data_d  = rdata_q;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q         <= S_IDLE;
            idx_q           <= 3'd0;
            fault_q         <= 1'b0;
            rdata_q         <= 32'd0;
            dev_req_q       <= '0;
            dev_rd_wr_q     <= 1'b0;
            dev_addr_q      <= '0;
            dev_wr_data_q   <= 32'd0;
            cpu_ack_q       <= 1'b0;
            cpu_ack_fault_q <= 1'b0;
            cpu_ack_data_q  <= 32'd0;
            busy_q          <= 1'b0;
`ifdef EIO_TIMEOUT_EN
            wdog_q          <= 16'd0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            fault_q         <= fault_d;
            rdata_q         <= rdata_d;
            dev_req_q       <= dev_req_d;
            dev_rd_wr_q     <= dev_rd_wr_d;
            dev_addr_q      <= dev_addr_d;
            dev_wr_data_q   <= dev_wr_data_d;
            cpu_ack_q       <= cpu_ack_d;
            cpu_ack_fault_q <= cpu_ack_fault_d;
            cpu_ack_data_q  <= cpu_ack_data_d;
            busy_q          <= busy_d;
`ifdef EIO_TIMEOUT_EN
            wdog_q          <= wdog_d;
`endif
        end
    end

    assign cpu_ack       = cpu_ack_q;
    assign cpu_ack_fault = cpu_ack_fault_q;
    assign cpu_ack_data  = cpu_ack_data_q;
    assign dev_req       = dev_req_q;
    assign dev_rd_wr     = dev_rd_wr_q;
    assign dev_addr      = dev_addr_q;
    assign dev_wr_data   = dev_wr_data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_eio_controller.sv
// Directed bench for eio_controller; timeout scenarios run only when EIO_TIMEOUT_EN is defined.
module tb_eio_controller;
    localparam int NUM_DEV = 4;

    logic                  clk_in = 1'b0;
    logic                  reset_in;
    logic                  cpu_req = 1'b0;
    logic                  cpu_rd_wr = 1'b0;
    logic [31:0]           cpu_addr = 32'd0;
    logic [31:0]           cpu_wr_data = 32'd0;
    logic                  cpu_ack;
    logic                  cpu_ack_fault;
    logic [31:0]           cpu_ack_data;
    logic [NUM_DEV-1:0]    dev_req;
    logic                  dev_rd_wr;
    logic [7:0]            dev_addr;
    logic [31:0]           dev_wr_data;
    logic [NUM_DEV-1:0]    dev_ack = '0;
    logic [32*NUM_DEV-1:0] dev_rd_data = '0;
    logic                  busy;

    int checks = 0;
    int failures = 0;

    eio_controller #(
        .NUM_DEV (NUM_DEV)
`ifdef EIO_TIMEOUT_EN
        ,
        .TO_CYCLES (10)
`endif
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .cpu_req       (cpu_req),
        .cpu_rd_wr     (cpu_rd_wr),
        .cpu_addr      (cpu_addr),
        .cpu_wr_data   (cpu_wr_data),
        .cpu_ack       (cpu_ack),
        .cpu_ack_fault (cpu_ack_fault),
        .cpu_ack_data  (cpu_ack_data),
        .dev_req       (dev_req),
        .dev_rd_wr     (dev_rd_wr),
        .dev_addr      (dev_addr),
        .dev_wr_data   (dev_wr_data),
        .dev_ack       (dev_ack),
        .dev_rd_data   (dev_rd_data),
        .busy          (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req     = 1'b1;
        cpu_rd_wr   = rw;
        cpu_addr    = addr;
        cpu_wr_data = wdata;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ack"},    32'(cpu_ack), 32'd0);
        check_val({tag, "_fault"},  32'(cpu_ack_fault), 32'd0);
        check_val({tag, "_data"},   cpu_ack_data, 32'd0);
        check_val({tag, "_req"},    32'(dev_req), 32'd0);
        check_val({tag, "_rdwr"},   32'(dev_rd_wr), 32'd0);
        check_val({tag, "_addr"},   32'(dev_addr), 32'd0);
        check_val({tag, "_wdata"},  dev_wr_data, 32'd0);
        check_val({tag, "_busy"},   32'(busy), 32'd0);
    endtask

    task automatic decode_fault(input string tag, input logic [31:0] addr);
        start_req(1'b0, addr, 32'd0);
        tick();
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_req0"}, 32'(dev_req), 32'd0);
        tick();
        check_val({tag, "_ack"},   32'(cpu_ack), 32'd1);
        check_val({tag, "_fault"}, 32'(cpu_ack_fault), 32'd1);
        check_val({tag, "_data"},  cpu_ack_data, 32'd0);
        check_val({tag, "_req1"},  32'(dev_req), 32'd0);
        $display("txn decode addr=%h fault=%b data=%h", addr, cpu_ack_fault, cpu_ack_data);
        cpu_req = 1'b0;
        tick();
        check_val({tag, "_ackdrop"}, 32'(cpu_ack), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset_in = 1'b0;
        #1 reset_in = 1'b1;
        #2;
        check_all_zero("reset");
        repeat (2) tick();
        reset_in = 1'b0;
        tick();

        // Read: device 1 acks in its first WAIT cycle
        dev_rd_data[63:32] = 32'hCAFE_F00D;
        start_req(1'b0, 32'h0040_0104, 32'd0);
        tick();
        check_val("rd_busy", 32'(busy), 32'd1);
        check_val("rd_req_issue", 32'(dev_req), 32'd0);
        tick();
        check_val("rd_dev_req", 32'(dev_req), 32'b0010);
        check_val("rd_dev_addr", 32'(dev_addr), 32'h04);
        check_val("rd_dir", 32'(dev_rd_wr), 32'd0);
        dev_ack = 4'b0010;
        tick();
        dev_ack = '0;
        check_val("rd_req_drop", 32'(dev_req), 32'd0);
        check_val("rd_ack_early", 32'(cpu_ack), 32'd0);
        tick();
        check_val("rd_ack", 32'(cpu_ack), 32'd1);
        check_val("rd_fault", 32'(cpu_ack_fault), 32'd0);
        check_val("rd_data", cpu_ack_data, 32'hCAFE_F00D);
        $display("txn read addr=%h data=%h fault=%b", cpu_addr, cpu_ack_data, cpu_ack_fault);
        cpu_req = 1'b0;
        tick();
        check_val("rd_ack_pulse", 32'(cpu_ack), 32'd0);
        check_val("rd_data_idle", cpu_ack_data, 32'd0);
        check_val("rd_busy_idle", 32'(busy), 32'd0);

        // Write: device 3 acks in its fifth WAIT cycle
        dev_rd_data[127:96] = 32'h1357_9BDF;
        start_req(1'b1, 32'h0040_0310, 32'hDEAD_BEEF);
        tick();
        tick();
        for (int k = 1; k <= 5; k++) begin
            check_val("wr_dev_req", 32'(dev_req), 32'b1000);
            check_val("wr_dir", 32'(dev_rd_wr), 32'd1);
            check_val("wr_wdata", dev_wr_data, 32'hDEAD_BEEF);
            check_val("wr_addr", 32'(dev_addr), 32'h10);
            check_val("wr_no_ack", 32'(cpu_ack), 32'd0);
            if (k == 5) dev_ack = 4'b1000;
            tick();
        end
        dev_ack = '0;
        check_val("wr_req_drop", 32'(dev_req), 32'd0);
        tick();
        check_val("wr_ack", 32'(cpu_ack), 32'd1);
        check_val("wr_fault", 32'(cpu_ack_fault), 32'd0);
        check_val("wr_data", cpu_ack_data, 32'h1357_9BDF);
        $display("txn write addr=%h wdata=%h fault=%b", cpu_addr, cpu_wr_data, cpu_ack_fault);
        cpu_req = 1'b0;
        tick();
        check_val("wr_ack_pulse", 32'(cpu_ack), 32'd0);

        decode_fault("dec_high", 32'h0040_0400);
        decode_fault("dec_low", 32'h003F_FFFC);

        // Stray ack from an unselected device is ignored
        dev_rd_data[95:64] = 32'h2468_ACE0;
        start_req(1'b0, 32'h0040_0200, 32'd0);
        tick();
        tick();
        dev_ack = 4'b0001;
        tick();
        dev_ack = '0;
        check_val("stray_req", 32'(dev_req), 32'b0100);
        check_val("stray_busy", 32'(busy), 32'd1);
        check_val("stray_no_ack", 32'(cpu_ack), 32'd0);
        dev_ack = 4'b0100;
        tick();
        dev_ack = '0;
        tick();
        check_val("stray_ack", 32'(cpu_ack), 32'd1);
        check_val("stray_fault", 32'(cpu_ack_fault), 32'd0);
        check_val("stray_data", cpu_ack_data, 32'h2468_ACE0);
        $display("txn read addr=%h data=%h fault=%b", cpu_addr, cpu_ack_data, cpu_ack_fault);
        cpu_req = 1'b0;
        tick();

`ifdef EIO_TIMEOUT_EN
        // Device 2 never acks: fault after 10 WAIT cycles, late ack ignored
        start_req(1'b0, 32'h0040_0200, 32'd0);
        tick();
        tick();
        for (int k = 1; k <= 10; k++) begin
            check_val("to_req_held", 32'(dev_req), 32'b0100);
            check_val("to_no_ack", 32'(cpu_ack), 32'd0);
            tick();
        end
        check_val("to_req_drop", 32'(dev_req), 32'd0);
        tick();
        check_val("to_ack", 32'(cpu_ack), 32'd1);
        check_val("to_fault", 32'(cpu_ack_fault), 32'd1);
        check_val("to_data", cpu_ack_data, 32'd0);
        $display("txn timeout addr=%h fault=%b data=%h", cpu_addr, cpu_ack_fault, cpu_ack_data);
        cpu_req = 1'b0;
        tick();
        tick();
        dev_ack = 4'b0100;
        tick();
        dev_ack = '0;
        for (int k = 0; k < 3; k++) begin
            check_val("to_late_ack", 32'(cpu_ack), 32'd0);
            check_val("to_late_busy", 32'(busy), 32'd0);
            tick();
        end

        // Ack on the expiry cycle wins
        dev_rd_data[95:64] = 32'hA5A5_5A5A;
        start_req(1'b0, 32'h0040_0200, 32'd0);
        tick();
        tick();
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) dev_ack = 4'b0100;
            tick();
        end
        dev_ack = '0;
        tick();
        check_val("exp_ack", 32'(cpu_ack), 32'd1);
        check_val("exp_fault", 32'(cpu_ack_fault), 32'd0);
        check_val("exp_data", cpu_ack_data, 32'hA5A5_5A5A);
        $display("txn expiry-ack addr=%h data=%h fault=%b", cpu_addr, cpu_ack_data, cpu_ack_fault);
        cpu_req = 1'b0;
        tick();
`endif

        // Reset during WAIT clears every output at once
        dev_rd_data[63:32] = 32'h1122_3344;
        start_req(1'b0, 32'h0040_0104, 32'd0);
        tick();
        tick();
        tick();
        check_val("rst_pre_req", 32'(dev_req), 32'b0010);
        #2 reset_in = 1'b1;
        #1;
        check_all_zero("rst_mid");
        $display("txn reset-mid-wait busy=%b dev_req=%b", busy, dev_req);
        cpu_req = 1'b0;
        tick();
        tick();
        reset_in = 1'b0;
        tick();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_no_ack", 32'(cpu_ack), 32'd0);
        start_req(1'b0, 32'h0040_0104, 32'd0);
        tick();
        tick();
        check_val("rst_rd_req", 32'(dev_req), 32'b0010);
        dev_ack = 4'b0010;
        tick();
        dev_ack = '0;
        tick();
        check_val("rst_rd_ack", 32'(cpu_ack), 32'd1);
        check_val("rst_rd_fault", 32'(cpu_ack_fault), 32'd0);
        check_val("rst_rd_data", cpu_ack_data, 32'h1122_3344);
        $display("txn read addr=%h data=%h fault=%b", cpu_addr, cpu_ack_data, cpu_ack_fault);
        cpu_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
